// File: rtl/seq_addsub_if.sv
// Operand/result handshake bundle for the chunk-serial adder/subtractor.
// master drives operands and accepts results; slave is the arithmetic unit.
interface seq_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_c;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             c_out;
  logic             overflow;

  modport master (
    output in_valid, in_a, in_b, in_c, in_sub, out_ready,
    input  in_ready, out_valid, sum_out, c_out, overflow
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_sub, out_ready,
    output in_ready, out_valid, sum_out, c_out, overflow
  );
endinterface

// File: rtl/seq_addsub.sv
// Chunk-serial add/sub: CHUNK bits per clock, LSB first, registered flags.
// Define SEQ_ADDSUB_SAT_EN to saturate sum_out on signed overflow.
module seq_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic clk,
  input  logic rst,
  seq_addsub_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] sum_q;
  logic             cy;
  logic             c_q;
  logic             ov_q;
  logic [IW-1:0]    idx;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] s_ch;
  logic             c_ch;
  logic             c_msb;
  logic             last;
  int               off;

  assign last = (idx == LAST);

  // one chunk of ripple; c_msb ends as the carry into the chunk's top bit
  always_comb begin
    off   = CHUNK * int'(idx);
    a_ch  = CHUNK'(a_reg >> off);
    b_ch  = CHUNK'(b_reg >> off);
    c_ch  = cy;
    c_msb = cy;
    s_ch  = '0;
    for (int i = 0; i < CHUNK; i++) begin
      c_msb   = c_ch;
      s_ch[i] = a_ch[i] ^ b_ch[i] ^ c_ch;
      c_ch    = (a_ch[i] & b_ch[i]) | (c_ch & (a_ch[i] ^ b_ch[i]));
    end
    acc_nxt = (acc & ~(CMASK << off)) | (WIDTH'(s_ch) << off);
    res     = acc_nxt;
`ifdef SEQ_ADDSUB_SAT_EN
    if (c_ch ^ c_msb)
      res = a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
`else
`endif
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.in_valid) state_nxt = RUN;
      RUN:  if (last) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cy    <= 1'b0;
      idx   <= '0;
      sum_q <= '0;
      c_q   <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (bus.in_valid) begin
            a_reg <= bus.in_a;
            b_reg <= bus.in_sub ? ~bus.in_b : bus.in_b;
            cy    <= bus.in_sub ^ bus.in_c;
            acc   <= '0;
            idx   <= '0;
          end
        end
        (state == RUN): begin
          acc <= acc_nxt;
          cy  <= c_ch;
          idx <= idx + IW'(1);
          if (last) begin
            sum_q <= res;
            c_q   <= c_ch;
            ov_q  <= c_ch ^ c_msb;
            idx   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.sum_out   = sum_q;
  assign bus.c_out     = c_q;
  assign bus.overflow  = ov_q;
endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench: vector table on an 8/2 instance, corner sequences,
// and a reference-model sweep over further WIDTH/CHUNK configurations.
module tb_seq_addsub;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sum;
    logic        c;
    logic        ov;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       sub;
    logic [7:0] sum_w;
    logic [7:0] sum_s;
    logic       cout;
    logic       ov;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  res_t sbq[$];

  seq_addsub_if #(.WIDTH(8)) m();
  seq_addsub #(.WIDTH(8), .CHUNK(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(m)
  );

  // sweep instances, driven through width-agnostic arrays
  logic [15:0] sw_a   [4];
  logic [15:0] sw_b   [4];
  logic        sw_c   [4];
  logic        sw_sub [4];
  logic        sw_iv  [4];
  logic        sw_rdy [4];
  logic        sw_ov_ [4];
  logic [15:0] sw_sum [4];
  logic        sw_co  [4];
  logic        sw_ovf [4];

  for (genvar g = 0; g < 4; g++) begin : sw
    localparam int W = (g == 3) ? 16 : 8;
    localparam int C = (g == 0) ? 1 : (g == 2) ? 8 : 4;
    seq_addsub_if #(.WIDTH(W)) ifc();
    seq_addsub #(.WIDTH(W), .CHUNK(C)) u (
      .clk(clk),
      .rst(rst),
      .bus(ifc)
    );
    assign ifc.in_a      = sw_a[g][W-1:0];
    assign ifc.in_b      = sw_b[g][W-1:0];
    assign ifc.in_c      = sw_c[g];
    assign ifc.in_sub    = sw_sub[g];
    assign ifc.in_valid  = sw_iv[g];
    assign ifc.out_ready = 1'b1;
    assign sw_rdy[g]     = ifc.in_ready;
    assign sw_ov_[g]     = ifc.out_valid;
    assign sw_sum[g]     = 16'(ifc.sum_out);
    assign sw_co[g]      = ifc.c_out;
    assign sw_ovf[g]     = ifc.overflow;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic res_t ref_op(input int w, input logic [15:0] a,
                                  input logic [15:0] b, input logic c,
                                  input logic sub);
    longint mask, aa, bb, full, s;
    logic am, bm, sm;
    res_t r;
    mask = (64'd1 << w) - 1;
    aa   = longint'(a) & mask;
    bb   = sub ? (~longint'(b) & mask) : (longint'(b) & mask);
    full = aa + bb + ((sub ? !c : c) ? 1 : 0);
    s    = full & mask;
    am   = aa[w-1];
    bm   = bb[w-1];
    sm   = s[w-1];
    r.c  = full[w];
    r.ov = (am == bm) && (sm != am);
`ifdef SEQ_ADDSUB_SAT_EN
    if (r.ov) s = am ? (longint'(1) << (w - 1)) : (mask >> 1);
`else
`endif
    r.sum = 16'(s);
    return r;
  endfunction

  task automatic m_start(input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic sub, input res_t e);
    @(negedge clk);
    m.in_a = a; m.in_b = b; m.in_c = c; m.in_sub = sub;
    m.in_valid = 1'b1;
    chk("accept_ready", m.in_ready, 1);
    @(posedge clk); #1;
    m.in_valid = 1'b0;
    sbq.push_back(e);
  endtask

  task automatic m_finish(input string nm);
    int k = 0;
    res_t e;
    while (!m.out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_lat"}, k, 4);
    if (sbq.size() == 0) begin
      chk({nm, "_sb_empty"}, 1, 0);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_sum"}, m.sum_out, e.sum[7:0]);
      chk({nm, "_cout"}, m.c_out, e.c);
      chk({nm, "_ovf"}, m.overflow, e.ov);
    end
  endtask

  task automatic sw_op(input int g, input int w, input int n,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic sub);
    int k = 0;
    res_t e;
    @(negedge clk);
    sw_a[g] = a; sw_b[g] = b; sw_c[g] = c; sw_sub[g] = sub;
    sw_iv[g] = 1'b1;
    chk($sformatf("sw%0d_ready", g), sw_rdy[g], 1);
    @(posedge clk); #1;
    sw_iv[g] = 1'b0;
    sbq.push_back(ref_op(w, a, b, c, sub));
    while (!sw_ov_[g] && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk($sformatf("sw%0d_lat", g), k, n);
    e = sbq.pop_front();
    chk($sformatf("sw%0d_res a=%h b=%h c=%b s=%b", g, a, b, c, sub),
        {sw_sum[g], sw_co[g], sw_ovf[g]}, {e.sum, e.c, e.ov});
    @(posedge clk); #1;
  endtask

  function automatic res_t vexp(input vec_t v);
    res_t r;
`ifdef SEQ_ADDSUB_SAT_EN
    r.sum = 16'(v.sum_s);
`else
    r.sum = 16'(v.sum_w);
`endif
    r.c  = v.cout;
    r.ov = v.ov;
    return r;
  endfunction

  initial begin
    vec_t vt[8];
    res_t e;
    logic seen;
    int   ws, ns;
    logic [15:0] ra, rb, mx;

    vt[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    vt[2] = '{8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 8'h4C, 1'b0, 1'b0};
    vt[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 8'hFE, 1'b0, 1'b0};
    vt[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1};
    vt[5] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0};
    vt[6] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b1};
    vt[7] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};

    m.in_valid = 1'b0; m.in_a = '0; m.in_b = '0;
    m.in_c = 1'b0; m.in_sub = 1'b0; m.out_ready = 1'b1;
    for (int g = 0; g < 4; g++) begin
      sw_a[g] = '0; sw_b[g] = '0; sw_c[g] = 1'b0;
      sw_sub[g] = 1'b0; sw_iv[g] = 1'b0;
    end

    repeat (2) @(negedge clk);
    chk("rst_in_ready", m.in_ready, 1);
    chk("rst_out_valid", m.out_valid, 0);
    chk("rst_sum", m.sum_out, 0);
    chk("rst_cout", m.c_out, 0);
    chk("rst_ovf", m.overflow, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      m_start(vt[i].a, vt[i].b, vt[i].c, vt[i].sub, vexp(vt[i]));
      m_finish($sformatf("vec%0d", i));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_idle", i), {m.in_ready, m.out_valid}, 2'b10);
    end

    // back-pressure: result held, second request ignored
    e = vexp(vt[0]);
    m.out_ready = 1'b0;
    m_start(vt[0].a, vt[0].b, vt[0].c, vt[0].sub, e);
    m_finish("bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      m.in_a = 8'h11; m.in_b = 8'h22; m.in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", i),
          {m.out_valid, m.in_ready, m.sum_out, m.c_out, m.overflow},
          {1'b1, 1'b0, e.sum[7:0], e.c, e.ov});
    end
    @(negedge clk);
    m.in_valid = 1'b0; m.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {m.in_ready, m.out_valid, m.sum_out},
        {1'b1, 1'b0, e.sum[7:0]});

    // reset while RUN is at chunk index 2
    m_start(vt[2].a, vt[2].b, vt[2].c, vt[2].sub, vexp(vt[2]));
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("rst_mid",
        {m.in_ready, m.out_valid, m.sum_out, m.c_out, m.overflow},
        {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (m.out_valid) seen = 1'b1;
    end
    chk("rst_no_valid", seen, 0);
    m_start(vt[4].a, vt[4].b, vt[4].c, vt[4].sub, vexp(vt[4]));
    m_finish("post_rst");

    for (int g = 0; g < 4; g++) begin
      ws = (g == 3) ? 16 : 8;
      ns = (g == 0) ? 8 : (g == 1) ? 2 : (g == 2) ? 1 : 4;
      mx = 16'((32'd1 << ws) - 1);
      sw_op(g, ws, ns, mx >> 1, 16'd1, 1'b0, 1'b0);
      sw_op(g, ws, ns, (mx >> 1) + 16'd1, 16'd1, 1'b0, 1'b1);
      for (int t = 0; t < 8; t++) begin
        ra = 16'($urandom) & mx;
        rb = 16'($urandom) & mx;
        sw_op(g, ws, ns, ra, rb, 1'($urandom), 1'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
